// File: rtl/serial_tx.sv
// serial_tx: parallel-in, asynchronous-serial-out frame transmitter.
// Latency: tx goes low on the acceptance edge; frame_done pulses
//    (DATA_W+2)*CLKS_PER_BIT cycles later (+CLKS_PER_BIT with parity).
// Backpressure: in_ready is low for the whole frame; in_valid/in_data are
//    ignored while busy, and at least one IDLE cycle separates frames.
//
// Ports:
//    clk        - sole clock, all state updates on posedge
//    r          - asynchronous active-low reset
//    in_valid   - producer has a word on in_data
//    in_data    - parallel word to send (DATA_W bits)
//    in_ready   - block accepts a word this cycle
//    tx         - serial line, idles high, driven from a register
//    busy       - frame in progress
//    frame_done - one-cycle pulse at the end of the stop bit
//
// Frame: start(0), DATA_W data bits LSB-first, [even parity], stop(1).
// Optional feature: define SERIAL_TX_PARITY_EN to insert the parity bit.

module serial_tx #(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 16
) (
   input  logic              clk,
   input  logic              r,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              tx,
   output logic              busy,
   output logic              frame_done
);

   localparam int TW = $clog2(CLKS_PER_BIT);
   localparam int IW = $clog2(DATA_W);
   localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);
   localparam logic [IW-1:0] IDX_LAST   = IW'(DATA_W - 1);

`ifdef SERIAL_TX_PARITY_EN
   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;
`else
   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } state_t;
`endif

   state_t            state_q, state_d;
   logic [TW-1:0]     timer_q, timer_d;
   logic [IW-1:0]     idx_q,   idx_d;
   logic [DATA_W-1:0] shreg_q, shreg_d;
   logic              tx_q,    tx_d;
   logic              ready_q, ready_d;
   logic              busy_q,  busy_d;
   logic              done_q,  done_d;
`ifdef SERIAL_TX_PARITY_EN
   // Parity is taken from the word at acceptance, since the shift
   // register no longer holds the full word once the data bits go out.
   logic              parity_q, parity_d;
`endif

   logic bit_end;

   // Last cycle of the current serial bit.
   assign bit_end = (timer_q == TIMER_LAST);

   always_comb begin
      state_d  = state_q;
      timer_d  = timer_q;
      idx_d    = idx_q;
      shreg_d  = shreg_q;
      tx_d     = tx_q;
      ready_d  = ready_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      parity_d = parity_q;
`endif

      case (state_q)
         S_IDLE: begin
            // Timer is held at zero so every frame starts on a clean bit.
            timer_d = '0;
            if (in_valid && ready_q) begin
               shreg_d  = in_data;
`ifdef SERIAL_TX_PARITY_EN
               parity_d = ^in_data;
`endif
               idx_d    = '0;
               state_d  = S_START;
               tx_d     = 1'b0;
               ready_d  = 1'b0;
               busy_d   = 1'b1;
            end
         end

         S_START: begin
            if (bit_end) begin
               timer_d = '0;
               idx_d   = '0;
               state_d = S_DATA;
               tx_d    = shreg_q[0];
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end

         S_DATA: begin
            if (bit_end) begin
               timer_d = '0;
               shreg_d = shreg_q >> 1;
               if (idx_q == IDX_LAST) begin
`ifdef SERIAL_TX_PARITY_EN
                  state_d = S_PARITY;
                  tx_d    = parity_q;
`else
                  state_d = S_STOP;
                  tx_d    = 1'b1;
`endif
               end else begin
                  idx_d = idx_q + 1'b1;
                  // tx is registered, so present the bit that becomes
                  // bit 0 after this shift.
                  tx_d  = shreg_q[1];
               end
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end

`ifdef SERIAL_TX_PARITY_EN
         S_PARITY: begin
            if (bit_end) begin
               timer_d = '0;
               state_d = S_STOP;
               tx_d    = 1'b1;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
`endif

         S_STOP: begin
            if (bit_end) begin
               timer_d = '0;
               idx_d   = '0;
               state_d = S_IDLE;
               tx_d    = 1'b1;
               ready_d = 1'b1;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end

         default: begin
            timer_d = '0;
            idx_d   = '0;
            state_d = S_IDLE;
            tx_d    = 1'b1;
            ready_d = 1'b1;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge r) begin
      if (!r) begin
         state_q  <= S_IDLE;
         timer_q  <= '0;
         idx_q    <= '0;
         shreg_q  <= '0;
         tx_q     <= 1'b1;
         ready_q  <= 1'b1;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         timer_q  <= timer_d;
         idx_q    <= idx_d;
         shreg_q  <= shreg_d;
         tx_q     <= tx_d;
         ready_q  <= ready_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
`ifdef SERIAL_TX_PARITY_EN
         parity_q <= parity_d;
`endif
      end
   end

   assign tx         = tx_q;
   assign in_ready   = ready_q;
   assign busy       = busy_q;
   assign frame_done = done_q;

endmodule

// File: tb/tb_serial_tx.sv
// tb_serial_tx: directed bench for serial_tx (DATA_W=8, CLKS_PER_BIT=4).
// Inputs change on the falling edge; outputs are sampled on the falling edge.

module tb_serial_tx;

   localparam int DW  = 8;
   localparam int CPB = 4;
`ifdef SERIAL_TX_PARITY_EN
   localparam int NB  = DW + 3;
`else
   localparam int NB  = DW + 2;
`endif
   localparam int FL  = NB * CPB;

   logic          clk;
   logic          r;
   logic          in_valid;
   logic [DW-1:0] in_data;
   logic          in_ready;
   logic          tx;
   logic          busy;
   logic          frame_done;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   serial_tx #(.DATA_W(DW), .CLKS_PER_BIT(CPB)) dut (
      .clk        (clk),
      .r          (r),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .tx         (tx),
      .busy       (busy),
      .frame_done (frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Expected line level for serial bit b of a frame carrying d.
   function automatic logic exp_bit(input logic [DW-1:0] d, input int b, input logic par);
      if (b == 0) return 1'b0;
      if (b <= DW) return d[b-1];
`ifdef SERIAL_TX_PARITY_EN
      if (b == DW + 1) return par;
`endif
      return 1'b1;
   endfunction

   // Present a word so that it is accepted on the next rising edge.
   task automatic start_frame(input logic [DW-1:0] d);
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = d;
      @(posedge clk);
   endtask

   // Called right after the acceptance edge; walks the whole frame.
   task automatic check_frame(input logic [DW-1:0] d, input logic par, input string nm,
                              input int chg_k, input logic [DW-1:0] chg_d,
                              input bit keep_valid, output int done_cyc);
      for (int k = 0; k < FL; k++) begin
         @(negedge clk);
         total++;
         if (tx !== exp_bit(d, k / CPB, par)) begin
            bad++;
            $display("FAIL %s_tx k=%0d got=%b exp=%b", nm, k, tx, exp_bit(d, k / CPB, par));
         end
         total++;
         if ({in_ready, busy, frame_done} !== 3'b010) begin
            bad++;
            $display("FAIL %s_status k=%0d got rdy/busy/done=%b exp=010", nm, k,
                     {in_ready, busy, frame_done});
         end
         if (k == 0 && !keep_valid) in_valid = 1'b0;
         if (k == chg_k) in_data = chg_d;
      end
      @(negedge clk);
      done_cyc = cyc;
      total++;
      if ({tx, in_ready, busy, frame_done} !== 4'b1101) begin
         bad++;
         $display("FAIL %s_done got tx/rdy/busy/done=%b exp=1101", nm,
                  {tx, in_ready, busy, frame_done});
      end
      if (!keep_valid) begin
         @(negedge clk);
         total++;
         if ({tx, in_ready, busy, frame_done} !== 4'b1100) begin
            bad++;
            $display("FAIL %s_idle got tx/rdy/busy/done=%b exp=1100", nm,
                     {tx, in_ready, busy, frame_done});
         end
      end
   endtask

   task automatic test_reset();
      r        = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      repeat (3) @(negedge clk);
      total++;
      if ({tx, in_ready, busy, frame_done} !== 4'b1100) begin
         bad++;
         $display("FAIL reset_hold got tx/rdy/busy/done=%b exp=1100", {tx, in_ready, busy, frame_done});
      end
      r = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         total++;
         if ({tx, in_ready, busy, frame_done} !== 4'b1100) begin
            bad++;
            $display("FAIL reset_idle cyc=%0d got tx/rdy/busy/done=%b exp=1100", i,
                     {tx, in_ready, busy, frame_done});
         end
      end
   endtask

   task automatic test_single();
      int dc;
      start_frame(8'hA5);
      check_frame(8'hA5, 1'b0, "single", -1, 8'h00, 1'b0, dc);
   endtask

   task automatic test_back_to_back();
      int d0, d1;
      start_frame(8'h00);
      check_frame(8'h00, 1'b0, "b2b0", 5, 8'hFF, 1'b1, d0);
      @(posedge clk);
      check_frame(8'hFF, 1'b0, "b2b1", -1, 8'h00, 1'b0, d1);
      total++;
      if (d1 - d0 != FL + 1) begin
         bad++;
         $display("FAIL b2b_period got=%0d exp=%0d", d1 - d0, FL + 1);
      end
   endtask

   task automatic test_ignored_input();
      int d0, d1;
      start_frame(8'hC3);
      check_frame(8'hC3, 1'b0, "ign0", 10, 8'h3C, 1'b1, d0);
      @(posedge clk);
      check_frame(8'h3C, 1'b0, "ign1", -1, 8'h00, 1'b0, d1);
   endtask

   task automatic test_reset_mid_frame();
      int dc;
      start_frame(8'h55);
      // Sample 13 falls inside the third data bit (samples 12..15).
      for (int k = 0; k < 14; k++) begin
         @(negedge clk);
         if (k == 0) in_valid = 1'b0;
      end
      total++;
      if ({tx, busy} !== 2'b11) begin
         bad++;
         $display("FAIL rstmid_pre got tx/busy=%b exp=11", {tx, busy});
      end
      #2 r = 1'b0;
      #1;
      total++;
      if ({tx, in_ready, busy, frame_done} !== 4'b1100) begin
         bad++;
         $display("FAIL rstmid_async got tx/rdy/busy/done=%b exp=1100", {tx, in_ready, busy, frame_done});
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         total++;
         if ({tx, in_ready, busy, frame_done} !== 4'b1100) begin
            bad++;
            $display("FAIL rstmid_hold i=%0d got tx/rdy/busy/done=%b exp=1100", i,
                     {tx, in_ready, busy, frame_done});
         end
      end
      r = 1'b1;
      @(negedge clk);
      total++;
      if ({tx, in_ready, busy, frame_done} !== 4'b1100) begin
         bad++;
         $display("FAIL rstmid_release got tx/rdy/busy/done=%b exp=1100", {tx, in_ready, busy, frame_done});
      end
      start_frame(8'h81);
      check_frame(8'h81, 1'b0, "after_rst", -1, 8'h00, 1'b0, dc);
   endtask

`ifdef SERIAL_TX_PARITY_EN
   task automatic test_parity();
      int dc;
      start_frame(8'h07);
      check_frame(8'h07, 1'b1, "par07", -1, 8'h00, 1'b0, dc);
      start_frame(8'h03);
      check_frame(8'h03, 1'b0, "par03", -1, 8'h00, 1'b0, dc);
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_ignored_input();
      test_reset_mid_frame();
`ifdef SERIAL_TX_PARITY_EN
      test_parity();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/serial_tx.md
Name: serial_tx

Overview:
- Transmit-side serialiser: takes a parallel word on a valid/ready handshake and drives it out on a single line as an asynchronous serial frame.
- Frame format: start bit, data bits LSB-first, optional parity bit, stop bit.
- Sits between a parallel producer register and an off-block serial line.
- Pairs with the team's serial receiver; line format and idle level must match it exactly.

Parameters:
- DATA_W, 8, number of data bits per frame; legal range 5..16.
- CLKS_PER_BIT, 16, clk cycles per serial bit; must be >= 2. Bit-timer width = clog2(CLKS_PER_BIT).

Ports:
- clk, input, 1, sole clock; all state updates on posedge.
- r, input, 1, asynchronous active-low reset.
- in_valid, input, 1, producer has a word on in_data.
- in_data, input, DATA_W, parallel word to send.
- in_ready, output, 1, block accepts a word this cycle.
- tx, output, 1, serial line; idles high.
- busy, output, 1, frame in progress.
- frame_done, output, 1, one-cycle pulse at end of stop bit.

Behaviour:
- Reset (r low, async, any time including mid-frame): state=IDLE, tx=1, in_ready=1, busy=0, frame_done=0, bit timer=0, bit index=0, shift register=0. The frame in flight is abandoned, with no partial stop bit. On r release, the block is in IDLE.
- States: IDLE, START, DATA, PARITY (only with the macro), STOP.
- IDLE: tx=1, in_ready=1, busy=0.
  - On a posedge with in_valid=1: latch in_data into the shift register, go to START, and set tx=0, in_ready=0, busy=1 on the same edge.
  - Acceptance happens only when in_valid and in_ready are both high.
- START: tx=0 for exactly CLKS_PER_BIT cycles, then DATA with bit index 0.
- DATA: tx = shift register bit 0, held CLKS_PER_BIT cycles per bit; shift right after each bit.
  - After DATA_W bits, go to PARITY if enabled, else STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles.
  - On the edge ending the last stop cycle: go to IDLE, set in_ready=1 and busy=0, and pulse frame_done=1 for exactly one cycle.
- Bit timer counts 0..CLKS_PER_BIT-1 and resets to 0 at every bit boundary; it never free-runs in IDLE.
- Frame length from acceptance edge to frame_done edge: (DATA_W+2)*CLKS_PER_BIT cycles, plus CLKS_PER_BIT with parity.
- Back-to-back frames: in_ready is high for at least one IDLE cycle between frames. With in_valid held high, the next frame is accepted on the first IDLE edge. Minimum frame-to-frame period is frame length + 1 cycle.
- in_data and in_valid are ignored while busy=1; the latched word cannot change mid-frame.
- tx is driven from a register; no combinational path from inputs to tx.

Optional Feature:
- Macro: SERIAL_TX_PARITY_EN.
- Defined:
  - The PARITY state is inserted after DATA.
  - tx = XOR of the DATA_W latched data bits (even parity: total ones in data+parity is even), held CLKS_PER_BIT cycles.
  - Frame length becomes (DATA_W+3)*CLKS_PER_BIT.
- Not defined:
  - No PARITY state and no parity logic; DATA goes directly to STOP.

Test Plan (CLKS_PER_BIT=4, DATA_W=8 unless noted):
- Reset: drive r=0 for 3 cycles, then r=1 -> tx=1, in_ready=1, busy=0, frame_done=0; no tx transition for 20 idle cycles.
- Single frame: in_valid=1, in_data=8'hA5 for one cycle.
  - Required: tx = 0 for 4 cycles, then 1,0,1,0,0,1,0,1 (LSB-first) at 4 cycles each, then 1 for 4 cycles.
  - frame_done pulses exactly 40 cycles after the acceptance edge; in_ready is low throughout the frame.
- Back-to-back: in_valid held high with 8'h00 then 8'hFF.
  - Required: exactly one idle cycle with tx=1 and in_ready=1 between frames; second frame data bits are all 1; two frame_done pulses 41 cycles apart.
- Ignored input: change in_data to 8'h3C mid-frame while in_valid=1 -> transmitted bits still match the originally latched word; 8'h3C is sent only if still valid at the next IDLE.
- Reset mid-frame: assert r=0 during the 3rd data bit of 8'h55 -> tx=1 and busy=0 asynchronously, with no frame_done. After release, a new 8'h81 frame transmits correctly.
- With SERIAL_TX_PARITY_EN:
  - 8'h07 -> parity bit 1; 8'h03 -> parity bit 0.
  - frame_done arrives 44 cycles after acceptance.
